// File: rtl/sequenciador_entrada.sv
// Stimulus sequencer: steps operand X through X_FIRST..X_LAST (with wrap-around),
// offering each value over a valid/ready handshake with a programmable inter-value gap.
module sequenciador_entrada #(
    parameter int               WIDTH   = 4,
    parameter int               DIV     = 4,
    parameter logic [WIDTH-1:0] X_FIRST = '0,
    parameter logic [WIDTH-1:0] X_LAST  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             x_ready,
    output logic [WIDTH-1:0] X,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   step_count
);

    localparam int SW = WIDTH + 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LOAD = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [WIDTH-1:0]  x_r, x_s;
    logic              x_valid_r, x_valid_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [WIDTH:0]    step_count_r, step_count_s;
    logic [PW-1:0]     presc_r, presc_s;

    // Next-state and next-output computation for the sweep FSM
    always_comb begin
        state_s      = state_r;
        x_s          = x_r;
        x_valid_s    = x_valid_r;
        busy_s       = busy_r;
        done_s       = done_r;
        step_count_s = step_count_r;
        presc_s      = presc_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    x_s          = X_FIRST;
                    x_valid_s    = 1'b1;
                    busy_s       = 1'b1;
                    done_s       = 1'b0;
                    step_count_s = '0;
                    state_s      = ST_SEND;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SEND: begin
                // X stays frozen until the consumer takes it; pause cannot retract valid
                if (x_valid_r && x_ready) begin
                    step_count_s = step_count_r + SW'(1);
                    x_valid_s    = 1'b0;
                    if (x_r == X_LAST) begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        presc_s = PRESC_LOAD;
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (pause) begin
                    presc_s = presc_r;
                end else if (presc_r != '0) begin
                    presc_s = presc_r - PW'(1);
                end else begin
                    x_s       = x_r + WIDTH'(1);
                    x_valid_s = 1'b1;
                    state_s   = ST_SEND;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                x_s          = '0;
                x_valid_s    = 1'b0;
                busy_s       = 1'b0;
                done_s       = 1'b0;
                step_count_s = '0;
                presc_s      = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            x_r          <= '0;
            x_valid_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            step_count_r <= '0;
            presc_r      <= '0;
        end else begin
            state_r      <= state_s;
            x_r          <= x_s;
            x_valid_r    <= x_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            step_count_r <= step_count_s;
            presc_r      <= presc_s;
        end
    end

    assign X          = x_r;
    assign x_valid    = x_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign step_count = step_count_r;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Directed testbench for sequenciador_entrada: default sweep, backpressure,
// pause, wrap-around, single-value and mid-sweep start/reset behaviour.
module tb_sequenciador_entrada;

    logic clk = 1'b0;
    logic rst, start, pause, x_ready;

    logic [3:0] x_a, x_b, x_c;
    logic       valid_a, valid_b, valid_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [4:0] step_a, step_b, step_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sequenciador_entrada dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .x_ready(x_ready),
        .X(x_a), .x_valid(valid_a), .busy(busy_a), .done(done_a), .step_count(step_a)
    );

    sequenciador_entrada #(.X_FIRST(4'd14), .X_LAST(4'd1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .x_ready(x_ready),
        .X(x_b), .x_valid(valid_b), .busy(busy_b), .done(done_b), .step_count(step_b)
    );

    sequenciador_entrada #(.X_FIRST(4'd9), .X_LAST(4'd9)) u_single (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .x_ready(x_ready),
        .X(x_c), .x_valid(valid_c), .busy(busy_c), .done(done_c), .step_count(step_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the selected instance raises x_valid; n==budget means timeout
    task automatic wait_valid(input int sel, input int budget, output int n);
        logic v;
        n = 0;
        v = (sel == 0) ? valid_a : valid_b;
        while (!v && n < budget) begin
            tick();
            n++;
            v = (sel == 0) ? valid_a : valid_b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; x_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run handshakes until dut presents value `target`
    task automatic advance_to(input int target);
        int n;
        x_ready = 1'b1;
        while (x_a != target[3:0] || !valid_a) begin
            tick();
            wait_valid(0, 40, n);
            if (n >= 40) begin
                checks++; errors++;
                $display("FAIL advance_timeout got X=%0d want %0d", x_a, target);
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pause = 1'b0; x_ready = 1'b0;
        tick(); tick();
        checks++; if (x_a !== 4'd0) begin errors++; $display("FAIL reset_x got %0d want 0", x_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
        checks++; if (step_a !== 5'd0) begin errors++; $display("FAIL reset_step got %0d want 0", step_a); end
        rst = 1'b0; start = 1'b0;
        tick();
        checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL idle_hold got valid=%b busy=%b want 0 0", valid_a, busy_a);
        end
    endtask

    task automatic test_full_sweep();
        int n;
        do_reset();
        x_ready = 1'b1;
        do_start();
        for (int v = 0; v < 16; v++) begin
            checks++; if (x_a !== v[3:0] || valid_a !== 1'b1) begin
                errors++; $display("FAIL sweep_x got X=%0d valid=%b want X=%0d valid=1", x_a, valid_a, v);
            end
            checks++; if (step_a !== v[4:0]) begin
                errors++; $display("FAIL sweep_step_pre got %0d want %0d", step_a, v);
            end
            tick();
            checks++; if (valid_a !== 1'b0 || step_a !== 5'(v + 1)) begin
                errors++; $display("FAIL sweep_hs got valid=%b step=%0d want 0 %0d", valid_a, step_a, v + 1);
            end
            if (v < 15) begin
                wait_valid(0, 40, n);
                checks++; if (n !== 4) begin
                    errors++; $display("FAIL sweep_gap got %0d want 4", n);
                end
            end else begin
                checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin
                    errors++; $display("FAIL sweep_done got done=%b busy=%b want 1 0", done_a, busy_a);
                end
            end
        end
        tick(); tick(); tick();
        checks++; if (done_a !== 1'b1 || step_a !== 5'd16 || valid_a !== 1'b0) begin
            errors++; $display("FAIL done_sticky got done=%b step=%0d valid=%b want 1 16 0", done_a, step_a, valid_a);
        end
        // start and x_ready together in DONE: start wins
        start = 1'b1; x_ready = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (x_a !== 4'd0 || valid_a !== 1'b1 || done_a !== 1'b0 || busy_a !== 1'b1 || step_a !== 5'd0) begin
            errors++; $display("FAIL restart_from_done got X=%0d v=%b d=%b b=%b s=%0d want 0 1 0 1 0",
                               x_a, valid_a, done_a, busy_a, step_a);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        do_start();
        advance_to(3);
        x_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (x_a !== 4'd3 || valid_a !== 1'b1 || step_a !== 5'd3) begin
                errors++; $display("FAIL bp_hold got X=%0d valid=%b step=%0d want 3 1 3", x_a, valid_a, step_a);
            end
        end
        x_ready = 1'b1;
        tick();
        checks++; if (step_a !== 5'd4 || valid_a !== 1'b0) begin
            errors++; $display("FAIL bp_release got step=%0d valid=%b want 4 0", step_a, valid_a);
        end
        wait_valid(0, 40, n);
        checks++; if (n + 1 !== 5 || x_a !== 4'd4) begin
            errors++; $display("FAIL bp_next got delay=%0d X=%0d want 5 4", n + 1, x_a);
        end
    endtask

    task automatic test_pause();
        int n;
        do_reset();
        do_start();
        advance_to(5);
        tick();
        pause = 1'b1;
        repeat (10) tick();
        checks++; if (valid_a !== 1'b0 || x_a !== 4'd5) begin
            errors++; $display("FAIL pause_frozen got valid=%b X=%0d want 0 5", valid_a, x_a);
        end
        pause = 1'b0;
        wait_valid(0, 40, n);
        checks++; if (1 + 10 + n !== 15 || x_a !== 4'd6) begin
            errors++; $display("FAIL pause_delay got delay=%0d X=%0d want 15 6", 1 + 10 + n, x_a);
        end
        x_ready = 1'b0; pause = 1'b1;
        tick();
        checks++; if (valid_a !== 1'b1 || x_a !== 4'd6) begin
            errors++; $display("FAIL pause_send_hold got valid=%b X=%0d want 1 6", valid_a, x_a);
        end
        x_ready = 1'b1;
        tick();
        checks++; if (valid_a !== 1'b0 || step_a !== 5'd7) begin
            errors++; $display("FAIL pause_send_hs got valid=%b step=%0d want 0 7", valid_a, step_a);
        end
        pause = 1'b0;
        wait_valid(0, 40, n);
        checks++; if (n !== 4 || x_a !== 4'd7) begin
            errors++; $display("FAIL pause_after got gap=%0d X=%0d want 4 7", n, x_a);
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd14, 4'd15, 4'd0, 4'd1};
        do_reset();
        x_ready = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            checks++; if (x_b !== exp_seq[i] || valid_b !== 1'b1) begin
                errors++; $display("FAIL wrap_x got X=%0d valid=%b want %0d 1", x_b, valid_b, exp_seq[i]);
            end
            tick();
            if (i < 3) begin
                wait_valid(1, 40, n);
            end else begin
                n = 0;
            end
        end
        checks++; if (step_b !== 5'd4 || done_b !== 1'b1 || busy_b !== 1'b0) begin
            errors++; $display("FAIL wrap_end got step=%0d done=%b busy=%b want 4 1 0", step_b, done_b, busy_b);
        end
        do_reset();
        x_ready = 1'b1;
        do_start();
        checks++; if (x_c !== 4'd9 || valid_c !== 1'b1) begin
            errors++; $display("FAIL single_x got X=%0d valid=%b want 9 1", x_c, valid_c);
        end
        tick();
        checks++; if (step_c !== 5'd1 || done_c !== 1'b1 || busy_c !== 1'b0 || valid_c !== 1'b0) begin
            errors++; $display("FAIL single_end got step=%0d done=%b busy=%b valid=%b want 1 1 0 0",
                               step_c, done_c, busy_c, valid_c);
        end
    endtask

    task automatic test_mid_sweep();
        int n;
        do_reset();
        do_start();
        advance_to(7);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (step_a !== 5'd8 || busy_a !== 1'b1 || valid_a !== 1'b0) begin
            errors++; $display("FAIL start_ignored got step=%0d busy=%b valid=%b want 8 1 0", step_a, busy_a, valid_a);
        end
        wait_valid(0, 40, n);
        checks++; if (x_a !== 4'd8 || n !== 4) begin
            errors++; $display("FAIL start_ignored_next got X=%0d gap=%0d want 8 4", x_a, n);
        end
        advance_to(9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (x_a !== 4'd0 || valid_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || step_a !== 5'd0) begin
            errors++; $display("FAIL mid_rst got X=%0d v=%b b=%b d=%b s=%0d want all 0",
                               x_a, valid_a, busy_a, done_a, step_a);
        end
        do_start();
        checks++; if (x_a !== 4'd0 || valid_a !== 1'b1 || busy_a !== 1'b1 || step_a !== 5'd0) begin
            errors++; $display("FAIL mid_restart got X=%0d v=%b b=%b s=%0d want 0 1 1 0", x_a, valid_a, busy_a, step_a);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; x_ready = 1'b0;
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_pause();
        test_wrap();
        test_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
